// File: rtl/inst_fetch_icache.sv
// inst_fetch_icache: PC + direct-mapped one-word-line I-cache feeding decode through a valid/ready slot
//   clk, rst (sync, active-low)            : clock and reset
//   jump_enable_in, jump_addr_in           : redirect from execute/commit, highest priority
//   id_ready_in                            : decoder accepts the slot this cycle
//   inst_valid_out, inst_out, inst_pc_out  : output slot
//   mem_if_enable_out, mem_if_addr_out     : miss request to the memory controller
//   mem_if_done_in, mem_if_inst_in         : one-cycle fill response
module inst_fetch_icache #(
  parameter int          ICACHE_ENTRIES = 64,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_enable_in,
  input  logic [31:0] jump_addr_in,
  input  logic        id_ready_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  output logic        mem_if_enable_out,
  output logic [31:0] mem_if_addr_out,
  input  logic        mem_if_done_in,
  input  logic [31:0] mem_if_inst_in
);
  localparam int IDX = $clog2(ICACHE_ENTRIES);
  localparam int TW  = 30 - IDX;
  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, addr_q, addr_d;
  logic valid_q, valid_d, req_q, req_d;
  logic [ICACHE_ENTRIES-1:0] lv_q, lv_d;
  logic [TW-1:0] tag_mem [ICACHE_ENTRIES];
  logic [31:0] data_mem [ICACHE_ENTRIES];
  logic [IDX-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic hit, fill;
  assign idx      = pc_q[IDX+1:2];
  assign tag      = pc_q[31:IDX+2];
  // Fills always target the outstanding request address, so a miss made stale by a jump
  // still lands in the line it belongs to.
  assign fill_idx = addr_q[IDX+1:2];
  assign fill_tag = addr_q[31:IDX+2];
  assign hit      = lv_q[idx] && tag_mem[idx] == tag;
  assign fill     = state_q != IDLE && mem_if_done_in;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    lv_d      = lv_q;
    valid_d   = valid_q && !id_ready_in;
    if (fill) begin
      lv_d[fill_idx] = 1'b1;
      req_d          = 1'b0;
      state_d        = IDLE;
    end
    if (jump_enable_in) begin
      pc_d    = jump_addr_in;
      valid_d = 1'b0;
      state_d = (state_q == MISS && !fill) ? DROP : state_d;
    end else if (state_q == IDLE && hit && (!valid_q || id_ready_in)) begin
      inst_d    = data_mem[idx];
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
    end else if (state_q == IDLE && !hit) begin
      state_d = MISS;
      req_d   = 1'b1;
      addr_d  = {pc_q[31:2], 2'b00};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      lv_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
      lv_q      <= lv_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_if_inst_in;
    end
  end
  assign inst_valid_out    = valid_q;
  assign inst_out          = inst_q;
  assign inst_pc_out       = inst_pc_q;
  assign mem_if_enable_out = req_q;
  assign mem_if_addr_out   = addr_q;
endmodule

// File: tb/tb_inst_fetch_icache.sv
// tb_inst_fetch_icache: directed + randomized bench against a transaction-level fetch model
module tb_inst_fetch_icache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic jump_enable_in = 1'b0;
  logic [31:0] jump_addr_in = '0;
  logic id_ready_in = 1'b0;
  logic mem_if_done_in = 1'b0;
  logic [31:0] mem_if_inst_in = '0;
  logic inst_valid_out, mem_if_enable_out;
  logic [31:0] inst_out, inst_pc_out, mem_if_addr_out;
  inst_fetch_icache dut (
    .clk(clk), .rst(rst),
    .jump_enable_in(jump_enable_in), .jump_addr_in(jump_addr_in),
    .id_ready_in(id_ready_in),
    .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
    .mem_if_enable_out(mem_if_enable_out), .mem_if_addr_out(mem_if_addr_out),
    .mem_if_done_in(mem_if_done_in), .mem_if_inst_in(mem_if_inst_in)
  );
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  // Reference: which word address each of the 64 direct-mapped lines holds, plus the
  // program-order PC the decoder should see next.
  logic mv [64];
  logic [31:0] ma [64];
  logic [31:0] exp_pc = '0;
  int wcnt = 0;
  int mem_lat = 1;
  int fixed_lat = 0;
  bit stray = 0;
  int rises = 0;
  logic [31:0] last_rise = '0;
  int consumed = 0;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction
  function automatic bit cached(input logic [31:0] a);
    return mv[a[7:2]] && ma[a[7:2]] == a;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask
  task automatic cycle();
    logic v, r, rq, j, d, rs;
    logic [31:0] i, p, ad, ja;
    if (mem_if_enable_out) begin
      if (wcnt == 0) mem_lat = fixed_lat != 0 ? fixed_lat : int'($urandom_range(1, 6));
      wcnt++;
      mem_if_done_in = wcnt == mem_lat;
      mem_if_inst_in = mem_if_done_in ? f(mem_if_addr_out) : 32'h0;
    end else begin
      wcnt = 0;
      mem_if_done_in = stray;
      mem_if_inst_in = stray ? ~f(mem_if_addr_out) : 32'h0;
    end
    v = inst_valid_out; i = inst_out; p = inst_pc_out; rq = mem_if_enable_out; ad = mem_if_addr_out;
    j = jump_enable_in; ja = jump_addr_in; r = id_ready_in; d = mem_if_done_in; rs = rst;
    if (!rs) begin
      foreach (mv[k]) mv[k] = 1'b0;
      exp_pc = 32'h0;
    end else begin
      if (v && r && !j) begin
        chk("consume_pc", p, exp_pc);
        chk("consume_inst", i, f(exp_pc));
        exp_pc += 32'd4;
        consumed++;
      end
      if (j) exp_pc = ja;
      if (d && rq) begin
        mv[ad[7:2]] = 1'b1;
        ma[ad[7:2]] = ad;
      end
    end
    @(posedge clk);
    #1;
    if (!rs) begin
      chk("rst_valid", 32'(inst_valid_out), 0);
      chk("rst_req", 32'(mem_if_enable_out), 0);
      chk("rst_inst", inst_out, 0);
      chk("rst_pc_out", inst_pc_out, 0);
      chk("rst_addr", mem_if_addr_out, 0);
    end else begin
      if (mem_if_enable_out && !rq) begin
        rises++;
        last_rise = mem_if_addr_out;
        chk("req_is_miss", 32'(cached(mem_if_addr_out)), 0);
        chk("req_align", 32'(mem_if_addr_out[1:0]), 0);
      end
      if (rq && mem_if_enable_out) chk("req_addr_stable", mem_if_addr_out, ad);
      if (rq && d) chk("req_drop_on_done", 32'(mem_if_enable_out), 0);
      if (j) chk("jump_kills_valid", 32'(inst_valid_out), 0);
      else if (v && !r) begin
        chk("stall_valid", 32'(inst_valid_out), 1);
        chk("stall_inst", inst_out, i);
        chk("stall_pc", inst_pc_out, p);
      end
    end
    jump_enable_in = 1'b0;
    mem_if_done_in = 1'b0;
    stray = 0;
  endtask
  task automatic jump(input logic [31:0] a);
    jump_enable_in = 1'b1;
    jump_addr_in = a;
    cycle();
  endtask
  task automatic wait_slot(input logic [31:0] a, input int bound, input string tag);
    bit ok;
    ok = 0;
    id_ready_in = 1'b1;
    for (int k = 0; k <= bound; k++) begin
      if (inst_valid_out && inst_pc_out == a) begin
        ok = 1;
        break;
      end
      if (k < bound) cycle();
    end
    chk(tag, 32'(ok), 1);
  endtask
  task automatic wait_rise(input int bound, input string tag);
    bit ok;
    int r0;
    ok = 0;
    r0 = rises;
    for (int k = 0; k < bound; k++) begin
      cycle();
      if (rises != r0) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, r0, c0;
    repeat (3) cycle();
    rst = 1'b1;
    fixed_lat = 5;
    id_ready_in = 1'b1;
    cycle();
    chk("cold_req", 32'(mem_if_enable_out), 1);
    chk("cold_addr", mem_if_addr_out, 0);
    n = 1;
    while (mem_if_enable_out && n < 20) begin
      cycle();
      if (mem_if_enable_out) n++;
    end
    chk("cold_req_cycles", 32'(n), 5);
    cycle();
    chk("cold_valid", 32'(inst_valid_out), 1);
    chk("cold_inst", inst_out, 32'h00500093);
    chk("cold_pc_out", inst_pc_out, 0);
    fixed_lat = 0;
    wait_slot(32'hC, 80, "warm_first_pass");
    jump(32'h0);
    r0 = rises;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("warm_valid", 32'(inst_valid_out), 1);
      chk("warm_pc_out", inst_pc_out, 32'(4 * k));
    end
    chk("warm_no_req", 32'(rises - r0), 0);
    jump(32'h0);
    cycle();
    id_ready_in = 1'b0;
    repeat (3) cycle();
    chk("bp_pc_frozen", inst_pc_out, 0);
    wait_slot(32'hC, 20, "bp_resume");
    fixed_lat = 4;
    jump(32'h40);
    wait_rise(10, "drop_rise_40");
    chk("drop_addr_40", last_rise, 32'h40);
    jump(32'h100);
    wait_rise(20, "drop_rise_100");
    chk("drop_addr_100", last_rise, 32'h100);
    wait_slot(32'h100, 20, "drop_slot_100");
    jump(32'h40);
    r0 = rises;
    wait_slot(32'h40, 10, "drop_filled_40");
    chk("drop_40_hit", 32'(rises - r0), 0);
    fixed_lat = 0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    r0 = rises;
    wait_slot(32'h0, 30, "conflict_a");
    jump(32'h100);
    wait_slot(32'h100, 30, "conflict_b");
    jump(32'h0);
    wait_slot(32'h0, 30, "conflict_c");
    chk("conflict_misses", 32'(rises - r0), 3);
    chk("conflict_last", last_rise, 0);
    id_ready_in = 1'b0;
    stray = 1;
    cycle();
    r0 = rises;
    jump(32'h0);
    wait_slot(32'h0, 5, "stray_slot");
    cycle();
    chk("stray_no_req", 32'(rises - r0), 0);
    jump(32'hFFFF_FFF8);
    wait_slot(32'h4, 60, "wrap_slot");
    fixed_lat = 6;
    jump(32'h200);
    wait_rise(10, "mid_rise");
    chk("mid_addr", last_rise, 32'h200);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    fixed_lat = 0;
    wait_rise(5, "post_rst_rise");
    chk("post_rst_addr", last_rise, 0);
    c0 = consumed;
    for (int k = 0; k < 3000; k++) begin
      id_ready_in = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) != 0;
      if ($urandom_range(0, 15) == 0) begin
        jump_enable_in = 1'b1;
        jump_addr_in = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0
                     : 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 15) * 4);
      end
      stray = !mem_if_enable_out && $urandom_range(0, 19) == 0;
      cycle();
    end
    rst = 1'b1;
    chk("random_progress", 32'(consumed - c0 > 300), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
